// File: rtl/alk_pkg.sv
// Shared definitions for the ALK ALU shift sequencer.
//   shift_mode_t : shift-mode encodings carried on mode_h / mode_r
//   IDLE/SHIFT/FIN : sequencer state encoding
//   is_left()    : direction of a mode code (reserved code 7 counts as left)
package alk_pkg;

    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        ASR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        LSL = 3'd5,
        LSR = 3'd6
    } shift_mode_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    // Reserved code 7 falls into the default and so shifts left like SHL.
    function automatic logic is_left(input logic [2:0] mode);
        case (mode)
            SHR, ASR, ROR, LSR: return 1'b0;
            default:            return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alk_shift_route.sv
// Combinational shift-in/shift-out routing for the ALU word end pads.
// Ports:
//   mode          in  latched shift mode
//   sio_lo_in_l   in  ALU_SIO[0] pad receive (active low)
//   sio_hi_in_l   in  ALU_SIO[WIDTH-1] pad receive (active low)
//   ext_sin_h     in  external link/Q shift-in bit
//   alu_sign_h    in  ALU MSB for arithmetic right shift
//   sout          out bit leaving the word (ungated)
//   sio_lo_out_l  out ALU_SIO[0] open-drain drive, 1 = released (ungated)
//   sio_hi_out_l  out ALU_SIO[WIDTH-1] open-drain drive, 1 = released (ungated)
module alk_shift_route
    import alk_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       sio_lo_in_l,
    input  logic       sio_hi_in_l,
    input  logic       ext_sin_h,
    input  logic       alu_sign_h,
    output logic       sout,
    output logic       sio_lo_out_l,
    output logic       sio_hi_out_l
);

    logic left;
    logic sin;

    always_comb begin
        sin = 1'b0;
        case (mode)
            ASR:      sin = alu_sign_h;
            // Rotates wrap the outgoing bit straight back in the same cycle.
            ROL:      sin = ~sio_hi_in_l;
            ROR:      sin = ~sio_lo_in_l;
            LSL, LSR: sin = ext_sin_h;
            default:  sin = 1'b0;
        endcase
    end

    always_comb begin
        left = is_left(mode);
        if (left) begin
            sout         = ~sio_hi_in_l;
            sio_lo_out_l = ~sin;
            sio_hi_out_l = 1'b1;
        end else begin
            sout         = ~sio_lo_in_l;
            sio_lo_out_l = 1'b1;
            sio_hi_out_l = ~sin;
        end
    end

endmodule

// File: rtl/alk_shift_seq.sv
// ALK ALU multi-cycle shift sequencer: one bit position per cycle,
// shift-in source chosen by mode, open-drain SIO pad drive, link capture
// and a start/busy/done handshake with microcode.
// Ports:
//   clk, reset_h        clock, synchronous active-high reset
//   start_h             begin operation (sampled in IDLE only)
//   mode_h, count_h     shift mode and distance (count saturates at WIDTH)
//   ext_sin_h           external shift-in bit
//   alu_sign_h          ALU MSB for ASR
//   sio_lo_in_l/hi_in_l pad receives (active low)
//   sio_lo_out_l/hi_out_l open-drain pad drives, 1 = released
//   shift_en_h          ALU shifts this cycle
//   sout_h              bit leaving the word this cycle
//   link_h              last shifted-out bit
//   busy_h, done_h      handshake status / one-cycle completion pulse
module alk_shift_seq
    import alk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          reset_h,
    input  logic          start_h,
    input  logic [2:0]    mode_h,
    input  logic [CW-1:0] count_h,
    input  logic          ext_sin_h,
    input  logic          alu_sign_h,
    input  logic          sio_lo_in_l,
    input  logic          sio_hi_in_l,
    output logic          sio_lo_out_l,
    output logic          sio_hi_out_l,
    output logic          shift_en_h,
    output logic          sout_h,
    output logic          link_h,
    output logic          busy_h,
    output logic          done_h
);

    // CW must be wide enough to hold WIDTH itself (2^CW > WIDTH).
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    mode_r;
    logic [CW-1:0] count_sat;
    logic          route_sout;
    logic          route_lo_l;
    logic          route_hi_l;

    assign count_sat = (count_h > WIDTH_C) ? WIDTH_C : count_h;

    alk_shift_route u_route (
        .mode         (mode_r),
        .sio_lo_in_l  (sio_lo_in_l),
        .sio_hi_in_l  (sio_hi_in_l),
        .ext_sin_h    (ext_sin_h),
        .alu_sign_h   (alu_sign_h),
        .sout         (route_sout),
        .sio_lo_out_l (route_lo_l),
        .sio_hi_out_l (route_hi_l)
    );

    always_ff @(posedge clk) begin
        if (reset_h) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_r <= '0;
            link_h <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_h) begin
                        mode_r <= mode_h;
                        cnt    <= count_sat;
                        state  <= (count_sat == '0) ? FIN : SHIFT;
                    end
                end
                SHIFT: begin
                    cnt    <= cnt - ONE_C;
                    link_h <= sout_h;
                    if (cnt == ONE_C) begin
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign shift_en_h = (state == SHIFT);
    assign busy_h     = (state != IDLE);
    assign done_h     = (state == FIN);

    // Routing is only meaningful while shifting; otherwise release both pads.
    assign sout_h       = shift_en_h & route_sout;
    assign sio_lo_out_l = route_lo_l | ~shift_en_h;
    assign sio_hi_out_l = route_hi_l | ~shift_en_h;

endmodule

// File: tb/tb_alk_shift_seq.sv
module tb_alk_shift_seq;

    logic       clk = 1'b0;
    logic       reset_h;
    logic       start_h;
    logic [2:0] mode_h;
    logic [5:0] count_h;
    logic       ext_sin_h;
    logic       alu_sign_h;
    logic       sio_lo_in_l;
    logic       sio_hi_in_l;
    logic       sio_lo_out_l;
    logic       sio_hi_out_l;
    logic       shift_en_h;
    logic       sout_h;
    logic       link_h;
    logic       busy_h;
    logic       done_h;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alk_shift_seq #(.WIDTH(32), .CW(6)) dut (
        .clk          (clk),
        .reset_h      (reset_h),
        .start_h      (start_h),
        .mode_h       (mode_h),
        .count_h      (count_h),
        .ext_sin_h    (ext_sin_h),
        .alu_sign_h   (alu_sign_h),
        .sio_lo_in_l  (sio_lo_in_l),
        .sio_hi_in_l  (sio_hi_in_l),
        .sio_lo_out_l (sio_lo_out_l),
        .sio_hi_out_l (sio_hi_out_l),
        .shift_en_h   (shift_en_h),
        .sout_h       (sout_h),
        .link_h       (link_h),
        .busy_h       (busy_h),
        .done_h       (done_h)
    );

    typedef struct {
        logic [2:0] mode;
        logic       sign;
        logic       ext;
        logic       hi_l;
        logic       lo_l;
        logic       e_sout;
        logic       e_lo;
        logic       e_hi;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start; returns 1 ns after the start edge, i.e. in cycle 1.
    // mode_h/count_h are then scrambled to prove they were latched.
    task automatic do_start(input logic [2:0] m, input logic [5:0] c);
        mode_h  = m;
        count_h = c;
        start_h = 1'b1;
        step();
        start_h = 1'b0;
        mode_h  = ~m;
        count_h = 6'd0;
    endtask

    task automatic chk_released(input string nm);
        chk({nm, "_en"},   {31'd0, shift_en_h},   32'd0);
        chk({nm, "_sout"}, {31'd0, sout_h},       32'd0);
        chk({nm, "_lo"},   {31'd0, sio_lo_out_l}, 32'd1);
        chk({nm, "_hi"},   {31'd0, sio_hi_out_l}, 32'd1);
    endtask

    initial begin
        logic [2:0] hi_pat;
        int         nshift;
        bit         seen_done;

        //            mode  sign  ext   hi_l  lo_l  sout  lo    hi
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; // SHL
        vecs[1]  = '{3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // SHR
        vecs[2]  = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // ASR
        vecs[3]  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // ROL
        vecs[4]  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // ROR
        vecs[5]  = '{3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // LSL
        vecs[6]  = '{3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // LSR
        vecs[7]  = '{3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; // code 7 = SHL
        vecs[8]  = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // ROL, 0 wraps
        vecs[9]  = '{3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // LSR ext=1
        vecs[10] = '{3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // ASR sign=0

        reset_h     = 1'b1;
        start_h     = 1'b0;
        mode_h      = 3'd0;
        count_h     = 6'd0;
        ext_sin_h   = 1'b0;
        alu_sign_h  = 1'b0;
        sio_lo_in_l = 1'b1;
        sio_hi_in_l = 1'b1;
        step();
        step();
        chk("rst_link", {31'd0, link_h}, 32'd0);
        chk("rst_busy", {31'd0, busy_h}, 32'd0);
        chk("rst_done", {31'd0, done_h}, 32'd0);
        chk_released("rst");
        reset_h = 1'b0;
        step();

        // Single-shift vectors covering every mode.
        for (int i = 0; i < 11; i++) begin
            alu_sign_h  = vecs[i].sign;
            ext_sin_h   = vecs[i].ext;
            sio_hi_in_l = vecs[i].hi_l;
            sio_lo_in_l = vecs[i].lo_l;
            do_start(vecs[i].mode, 6'd1);
            chk($sformatf("v%0d_en", i),   {31'd0, shift_en_h},   32'd1);
            chk($sformatf("v%0d_busy", i), {31'd0, busy_h},       32'd1);
            chk($sformatf("v%0d_sout", i), {31'd0, sout_h},       {31'd0, vecs[i].e_sout});
            chk($sformatf("v%0d_lo", i),   {31'd0, sio_lo_out_l}, {31'd0, vecs[i].e_lo});
            chk($sformatf("v%0d_hi", i),   {31'd0, sio_hi_out_l}, {31'd0, vecs[i].e_hi});
            step();
            chk($sformatf("v%0d_done", i), {31'd0, done_h}, 32'd1);
            chk($sformatf("v%0d_link", i), {31'd0, link_h}, {31'd0, vecs[i].e_sout});
            chk_released($sformatf("v%0d_fin", i));
            step();
            chk($sformatf("v%0d_idle", i), {31'd0, busy_h}, 32'd0);
            chk($sformatf("v%0d_nodone", i), {31'd0, done_h}, 32'd0);
        end

        // SHL count 3, pad pattern 0,1,0 -> sout 1,0,1.
        alu_sign_h = 1'b0;
        ext_sin_h  = 1'b1;
        hi_pat     = 3'b010;
        sio_lo_in_l = 1'b0;
        sio_hi_in_l = hi_pat[0];
        do_start(3'd0, 6'd3);
        for (int c = 0; c < 3; c++) begin
            sio_hi_in_l = hi_pat[c];
            #1;
            chk($sformatf("shl3_en%0d", c),   {31'd0, shift_en_h},   32'd1);
            chk($sformatf("shl3_sout%0d", c), {31'd0, sout_h},       {31'd0, ~hi_pat[c]});
            chk($sformatf("shl3_lo%0d", c),   {31'd0, sio_lo_out_l}, 32'd1);
            chk($sformatf("shl3_hi%0d", c),   {31'd0, sio_hi_out_l}, 32'd1);
            chk($sformatf("shl3_done%0d", c), {31'd0, done_h},       32'd0);
            step();
        end
        chk("shl3_done", {31'd0, done_h}, 32'd1);
        chk("shl3_link", {31'd0, link_h}, 32'd1);
        chk("shl3_en_off", {31'd0, shift_en_h}, 32'd0);
        step();
        chk("shl3_busy_off", {31'd0, busy_h}, 32'd0);

        // Count 0: done one cycle after start, no shift, link kept at 1.
        sio_hi_in_l = 1'b1;
        do_start(3'd0, 6'd0);
        chk("c0_done", {31'd0, done_h},     32'd1);
        chk("c0_en",   {31'd0, shift_en_h}, 32'd0);
        chk("c0_link", {31'd0, link_h},     32'd1);
        step();
        chk("c0_idle", {31'd0, busy_h}, 32'd0);

        // ASR count 2, sign 1: hi pad pulled low both cycles.
        alu_sign_h  = 1'b1;
        sio_lo_in_l = 1'b0;
        sio_hi_in_l = 1'b1;
        do_start(3'd2, 6'd2);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("asr_hi%0d", c), {31'd0, sio_hi_out_l}, 32'd0);
            chk($sformatf("asr_lo%0d", c), {31'd0, sio_lo_out_l}, 32'd1);
            chk($sformatf("asr_sout%0d", c), {31'd0, sout_h}, 32'd1);
            step();
        end
        chk("asr_done", {31'd0, done_h}, 32'd1);
        chk_released("asr_fin");
        step();

        // Count 45 saturates to 32 shift cycles.
        sio_hi_in_l = 1'b0;
        do_start(3'd0, 6'd45);
        nshift    = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done_h) begin
                seen_done = 1'b1;
                break;
            end
            if (shift_en_h) nshift++;
            step();
        end
        chk("sat_done_seen", {31'd0, seen_done}, 32'd1);
        chk("sat_shifts", nshift, 32'd32);
        step();
        chk("sat_idle", {31'd0, busy_h}, 32'd0);

        // Start while busy (SHIFT and FIN) must not restart.
        sio_hi_in_l = 1'b1;
        do_start(3'd0, 6'd2);
        start_h = 1'b1;
        count_h = 6'd5;
        step();
        chk("busy_st_en", {31'd0, shift_en_h}, 32'd1);
        step();
        chk("busy_st_done", {31'd0, done_h}, 32'd1);
        step();
        start_h = 1'b0;
        chk("busy_st_idle", {31'd0, busy_h}, 32'd0);
        step();
        chk("busy_st_still_idle", {31'd0, busy_h}, 32'd0);

        // LSL count 5 with reset in shift cycle 2, plus a start while busy.
        ext_sin_h   = 1'b1;
        sio_hi_in_l = 1'b0;
        sio_lo_in_l = 1'b1;
        do_start(3'd5, 6'd5);
        chk("rmid_lo1", {31'd0, sio_lo_out_l}, 32'd0);
        start_h = 1'b1;
        mode_h  = 3'd0;
        count_h = 6'd1;
        step();
        start_h = 1'b0;
        chk("rmid_en2",   {31'd0, shift_en_h},   32'd1);
        chk("rmid_lo2",   {31'd0, sio_lo_out_l}, 32'd0);
        chk("rmid_link2", {31'd0, link_h},       32'd1);
        reset_h = 1'b1;
        step();
        reset_h = 1'b0;
        chk("rmid_busy", {31'd0, busy_h}, 32'd0);
        chk("rmid_done", {31'd0, done_h}, 32'd0);
        chk("rmid_link", {31'd0, link_h}, 32'd0);
        chk_released("rmid");
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("rmid_nodone%0d", c), {31'd0, done_h | busy_h}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
